// File: rtl/bp_io_wormhole_arbiter_pkg.sv
// Shared definitions for the IO-NoC wormhole arbiter: header length field
// placement and arbiter FSM state encodings.
package bp_io_wormhole_arbiter_pkg;

   localparam int io_noc_len_width_gp  = 4;
   localparam int io_noc_len_offset_gp = 8;

   localparam int         state_width_gp = 1;
   localparam logic [0:0] e_idle         = 1'b0;
   localparam logic [0:0] e_locked       = 1'b1;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bp_io_wormhole_arbiter_if.sv
// Requester-side and shared-link handshake bundle of the wormhole arbiter.
interface bp_io_wormhole_arbiter_if #(
   parameter int num_req_p    = 4,
   parameter int flit_width_p = 64
);
   logic [num_req_p-1:0]              en_i;
   logic [num_req_p-1:0]              v_i;
   logic [num_req_p*flit_width_p-1:0] data_i;
   logic [num_req_p-1:0]              ready_and_o;
   logic                              v_o;
   logic [flit_width_p-1:0]           data_o;
   logic                              ready_and_i;
   logic [num_req_p-1:0]              grant_o;
   logic                              busy_o;

   modport master (
      output en_i, v_i, data_i, ready_and_i,
      input  ready_and_o, v_o, data_o, grant_o, busy_o
   );

   modport slave (
      input  en_i, v_i, data_i, ready_and_i,
      output ready_and_o, v_o, data_o, grant_o, busy_o
   );
endinterface

// File: rtl/bp_io_rr_pick.sv
// Rotating-priority picker: first request at or after ptr_i, wrapping.
module bp_io_rr_pick
   import bp_io_wormhole_arbiter_pkg::*;
#(
   parameter  int num_req_p = 4,
   localparam int idx_w_lp  = idx_width(num_req_p)
) (
   input  logic [num_req_p-1:0] req_i,
   input  logic [idx_w_lp-1:0]  ptr_i,
   output logic [num_req_p-1:0] grant_o,
   output logic [idx_w_lp-1:0]  idx_o,
   output logic                 v_o
);

   always_comb begin
      int j;
      j       = 0;
      grant_o = '0;
      idx_o   = '0;
      v_o     = 1'b0;
      for (int k = 0; k < num_req_p; k++) begin
         j = (int'(ptr_i) + k) % num_req_p;
         if (!v_o && req_i[j]) begin
            v_o        = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = idx_w_lp'(j);
         end
      end
   end

endmodule

// File: rtl/bp_io_wormhole_arbiter.sv
// Packet-atomic round-robin arbiter: one owner holds the shared IO link from
// header flit through its last body flit.
module bp_io_wormhole_arbiter
   import bp_io_wormhole_arbiter_pkg::*;
#(
   parameter int num_req_p    = 4,
   parameter int flit_width_p = 64,
   parameter int len_width_p  = io_noc_len_width_gp,
   parameter int len_offset_p = io_noc_len_offset_gp
) (
   input logic                     clk_i,
   input logic                     reset_n_i,
   bp_io_wormhole_arbiter_if.slave io
);

   localparam int idx_w_lp = idx_width(num_req_p);

   logic [state_width_gp-1:0]             state_r;
   logic [idx_w_lp-1:0]                   owner_r, rr_r, pick_idx, owner;
   logic [len_width_p-1:0]                cnt_r, hdr_len;
   logic [num_req_p-1:0]                  cand, pick_grant, owner_oh;
   logic                                  pick_v, locked, active, xfer;
   logic [num_req_p-1:0][flit_width_p-1:0] data_arr;

   assign locked = (state_r == e_locked);

   // Candidates are masked by reset so nothing leaks out while reset is held.
   assign cand = io.v_i & io.en_i & {num_req_p{reset_n_i}};

   bp_io_rr_pick #(.num_req_p(num_req_p)) pick (
      .req_i  (cand),
      .ptr_i  (rr_r),
      .grant_o(pick_grant),
      .idx_o  (pick_idx),
      .v_o    (pick_v)
   );

   assign owner  = locked ? owner_r : pick_idx;
   assign active = locked | pick_v;

   always_comb begin
      owner_oh = pick_grant;
      if (locked) begin
         owner_oh          = '0;
         owner_oh[owner_r] = 1'b1;
      end
   end

   assign data_arr       = io.data_i;
   assign io.grant_o     = owner_oh;
   assign io.v_o         = active & io.v_i[owner];
   assign io.data_o      = data_arr[owner];
   assign io.ready_and_o = owner_oh & {num_req_p{io.ready_and_i}};
   assign io.busy_o      = locked;

   assign xfer    = io.v_o & io.ready_and_i;
   assign hdr_len = io.data_o[len_offset_p +: len_width_p];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= e_idle;
         owner_r <= '0;
         rr_r    <= '0;
         cnt_r   <= '0;
      end else if (xfer) begin
         if (!locked) begin
            rr_r <= (owner == idx_w_lp'(num_req_p - 1)) ? '0 : owner + 1'b1;
            // Zero-length headers are whole packets; the link stays free.
            if (hdr_len != '0) begin
               state_r <= e_locked;
               cnt_r   <= hdr_len;
               owner_r <= owner;
            end
         end else begin
            cnt_r <= cnt_r - 1'b1;
            if (cnt_r == len_width_p'(1)) state_r <= e_idle;
         end
      end
   end

endmodule

// File: tb/tb_bp_io_wormhole_arbiter.sv
// Directed scenarios plus a randomized run against a packet-level model.
module tb_bp_io_wormhole_arbiter;

   localparam int N  = 4;
   localparam int W  = 64;
   localparam int LW = 4;
   localparam int LO = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp   = 0;
   int   n_err   = 0;

   always #5 clk = ~clk;

   bp_io_wormhole_arbiter_if #(.num_req_p(N), .flit_width_p(W)) io ();

   bp_io_wormhole_arbiter #(
      .num_req_p(N), .flit_width_p(W), .len_width_p(LW), .len_offset_p(LO)
   ) dut (
      .clk_i    (clk),
      .reset_n_i(reset_n),
      .io       (io)
   );

   logic [W-1:0] cur [N];

   function automatic logic [W-1:0] mk_flit(input int req, input int seq, input int len);
      logic [W-1:0] f;
      f            = {$urandom, $urandom};
      f[W-1 -: 4]  = 4'(req);
      f[W-5 -: 8]  = 8'(seq);
      f[LO +: LW]  = LW'(len);
      return f;
   endfunction

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] en, input logic rdy);
      io.v_i         = v;
      io.en_i        = en;
      io.ready_and_i = rdy;
      for (int i = 0; i < N; i++) io.data_i[i*W +: W] = cur[i];
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) cur[i] = '0;
      drive('0, '1, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_reset;
      logic [2*N+1:0] obs;
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) cur[i] = mk_flit(i, 0, 0);
      drive('1, '1, 1'b1);
      for (int r = 0; r < 2; r++) begin
         #2;
         obs = {io.grant_o, io.ready_and_o, io.v_o, io.busy_o};
         n_cmp++;
         if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs r=%0d got %b exp 0", r, obs);
         end
         @(posedge clk);
      end
      #1;
      drive('0, '1, 1'b0);
      reset_n = 1'b1;
   endtask

   task automatic test_rr_fairness;
      logic [2*N+1:0] obs;
      logic [N-1:0]   eg;
      do_reset;
      for (int i = 0; i < N; i++) cur[i] = mk_flit(i, 0, 0);
      drive('1, '1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         eg  = N'(1) << (k % N);
         obs = {io.grant_o, io.ready_and_o, io.v_o, io.busy_o};
         n_cmp++;
         if (obs !== {eg, eg, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL rr_order k=%0d got %b exp %b", k, obs, {eg, eg, 1'b1, 1'b0});
         end
         n_cmp++;
         if (io.data_o !== cur[k % N]) begin
            n_err++;
            $display("FAIL rr_data k=%0d got %h exp %h", k, io.data_o, cur[k % N]);
         end
         next_cycle;
      end
   endtask

   task automatic test_atomicity;
      logic [2*N+1:0] obs;
      logic [N-1:0]   eg;
      logic           eb;
      int             own;
      do_reset;
      cur[1] = mk_flit(1, 0, 3);
      cur[2] = mk_flit(2, 0, 0);
      for (int k = 0; k < 5; k++) begin
         if (k >= 1 && k <= 3) cur[1] = mk_flit(1, k, $urandom_range(15, 1));
         drive((k == 4) ? N'(4) : N'(6), '1, 1'b1);
         own = (k == 4) ? 2 : 1;
         eb  = (k >= 1 && k <= 3);
         eg  = N'(1) << own;
         @(negedge clk);
         obs = {io.grant_o, io.ready_and_o, io.v_o, io.busy_o};
         n_cmp++;
         if (obs !== {eg, eg, 1'b1, eb}) begin
            n_err++;
            $display("FAIL atomic_ctl k=%0d got %b exp %b", k, obs, {eg, eg, 1'b1, eb});
         end
         n_cmp++;
         if (io.data_o !== cur[own]) begin
            n_err++;
            $display("FAIL atomic_data k=%0d got %h exp %h", k, io.data_o, cur[own]);
         end
         next_cycle;
      end
   endtask

   task automatic test_backpressure;
      logic [2*N+1:0] obs;
      logic [N-1:0]   eg, er;
      int rp [6] = '{1, 0, 0, 1, 1, 1};
      int bz [6] = '{0, 1, 1, 1, 1, 0};
      int own;
      do_reset;
      cur[0] = mk_flit(0, 0, 2);
      cur[3] = mk_flit(3, 0, 0);
      for (int k = 0; k < 6; k++) begin
         if (k == 1) cur[0] = mk_flit(0, 1, $urandom_range(15, 1));
         if (k == 4) cur[0] = mk_flit(0, 2, $urandom_range(15, 1));
         drive((k == 5) ? N'(8) : N'(9), '1, rp[k][0]);
         own = (k == 5) ? 3 : 0;
         eg  = N'(1) << own;
         er  = eg & {N{rp[k][0]}};
         @(negedge clk);
         obs = {io.grant_o, io.ready_and_o, io.v_o, io.busy_o};
         n_cmp++;
         if (obs !== {eg, er, 1'b1, bz[k][0]}) begin
            n_err++;
            $display("FAIL backpressure k=%0d got %b exp %b", k, obs, {eg, er, 1'b1, bz[k][0]});
         end
         n_cmp++;
         if (io.data_o !== cur[own]) begin
            n_err++;
            $display("FAIL bp_data k=%0d got %h exp %h", k, io.data_o, cur[own]);
         end
         next_cycle;
      end
   endtask

   task automatic test_enable;
      logic [2*N+1:0] obs;
      logic [N-1:0]   eg;
      int ord [9] = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
      do_reset;
      for (int i = 0; i < N; i++) cur[i] = mk_flit(i, 0, 0);
      drive('1, N'(11), 1'b1);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         eg  = N'(1) << ord[k];
         obs = {io.grant_o, io.ready_and_o, io.v_o, io.busy_o};
         n_cmp++;
         if (obs !== {eg, eg, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL enable_mask k=%0d got %b exp %b", k, obs, {eg, eg, 1'b1, 1'b0});
         end
         next_cycle;
      end
      // Dropping the owner's enable mid-packet must not cut the packet short.
      do_reset;
      cur[0] = mk_flit(0, 0, 2);
      for (int k = 0; k < 4; k++) begin
         if (k == 1 || k == 2) cur[0] = mk_flit(0, k, $urandom_range(15, 1));
         if (k == 3)           cur[0] = mk_flit(0, 3, 0);
         drive(N'(1), (k == 0) ? N'(15) : N'(14), 1'b1);
         eg = (k < 3) ? N'(1) : N'(0);
         @(negedge clk);
         obs = {io.grant_o, io.ready_and_o, io.v_o, io.busy_o};
         n_cmp++;
         if (obs !== {eg, eg, (k < 3), (k == 1 || k == 2)}) begin
            n_err++;
            $display("FAIL enable_midpkt k=%0d got %b exp %b", k, obs,
                     {eg, eg, (k < 3), (k == 1 || k == 2)});
         end
         next_cycle;
      end
   endtask

   task automatic test_async_reset;
      logic [2*N+1:0] obs;
      do_reset;
      for (int i = 0; i < N; i++) cur[i] = mk_flit(i, 0, 0);
      cur[2] = mk_flit(2, 0, 5);
      drive(N'(4), '1, 1'b1);
      next_cycle;
      cur[2] = mk_flit(2, 1, 7);
      drive('1, '1, 1'b1);
      @(negedge clk);
      n_cmp++;
      if ({io.grant_o, io.busy_o} !== {N'(4), 1'b1}) begin
         n_err++;
         $display("FAIL async_locked got %b exp %b", {io.grant_o, io.busy_o}, {N'(4), 1'b1});
      end
      next_cycle;
      #1 reset_n = 1'b0;
      #1;
      obs = {io.grant_o, io.ready_and_o, io.v_o, io.busy_o};
      n_cmp++;
      if (obs !== '0) begin
         n_err++;
         $display("FAIL async_reset got %b exp 0", obs);
      end
      @(posedge clk);
      #1;
      cur[2] = mk_flit(2, 2, 0);
      drive('1, '1, 1'b1);
      reset_n = 1'b1;
      @(negedge clk);
      obs = {io.grant_o, io.ready_and_o, io.v_o, io.busy_o};
      n_cmp++;
      if (obs !== {N'(1), N'(1), 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL post_reset_grant got %b exp %b", obs, {N'(1), N'(1), 1'b1, 1'b0});
      end
      next_cycle;
   endtask

   task automatic test_random;
      logic [2*N+1:0] obs;
      logic [N-1:0]   v, en, eg, er;
      logic           rdy, ev, eb;
      int m_rr, m_owner, m_cnt, own, len, j;
      bit has [N];
      int rem [N];
      int seq [N];
      do_reset;
      m_rr = 0; m_owner = 0; m_cnt = 0;
      en = '1;
      v  = '0;
      for (int i = 0; i < N; i++) begin
         has[i] = 1'b0; rem[i] = 0; seq[i] = 0;
      end
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!has[i] && $urandom_range(3) != 0) begin
               if (rem[i] == 0)
                  len = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(4, 1));
               else
                  len = int'($urandom_range(15));
               cur[i] = mk_flit(i, seq[i], len);
               seq[i]++;
               has[i] = 1'b1;
            end
            v[i] = has[i];
         end
         if ($urandom_range(7) == 0) en = N'($urandom);
         rdy = ($urandom_range(3) != 0);
         drive(v, en, rdy);

         // Packet owner by the round-robin rule, or the packet holder.
         own = -1;
         if (m_cnt > 0) own = m_owner;
         else
            for (int k = 0; k < N; k++) begin
               j = (m_rr + k) % N;
               if (own < 0 && v[j] && en[j]) own = j;
            end
         eg = (own >= 0) ? N'(1) << own : '0;
         ev = (own >= 0) ? v[own] : 1'b0;
         er = eg & {N{rdy}};
         eb = (m_cnt > 0);

         @(negedge clk);
         obs = {io.grant_o, io.ready_and_o, io.v_o, io.busy_o};
         n_cmp++;
         if (obs !== {eg, er, ev, eb}) begin
            n_err++;
            $display("FAIL random_ctl c=%0d got %b exp %b", c, obs, {eg, er, ev, eb});
         end
         if (ev) begin
            n_cmp++;
            if (io.data_o !== cur[own]) begin
               n_err++;
               $display("FAIL random_data c=%0d got %h exp %h", c, io.data_o, cur[own]);
            end
         end

         if (ev && rdy) begin
            has[own] = 1'b0;
            if (m_cnt == 0) begin
               len      = int'(cur[own][LO +: LW]);
               m_rr     = (own + 1) % N;
               rem[own] = len;
               if (len != 0) begin
                  m_cnt   = len;
                  m_owner = own;
               end
            end else begin
               m_cnt--;
               rem[own]--;
            end
         end
         next_cycle;
      end
   endtask

   initial begin
      test_reset;
      test_rr_fairness;
      test_atomicity;
      test_backpressure;
      test_enable;
      test_async_reset;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
